// File: rtl/pc_unit_if.sv
// Request/status bundle between the interrupt/branch monitor and the fetch PC unit.
// master drives redirects and mode; slave is the PC unit itself.
interface pc_unit_if;
    logic        J;
    logic [15:0] J_R;
    logic        Store_Current;
    logic        IFID_Stall;
    logic        rti;
    logic [1:0]  Mode;
    logic [15:0] PC;
    logic        PC_valid;
    logic        Illegal_PC;
    logic        rstack_empty;
    logic        rstack_ovf;

    modport master (
        output J, J_R, Store_Current, IFID_Stall, rti, Mode,
        input  PC, PC_valid, Illegal_PC, rstack_empty, rstack_ovf
    );

    modport slave (
        input  J, J_R, Store_Current, IFID_Stall, rti, Mode,
        output PC, PC_valid, Illegal_PC, rstack_empty, rstack_ovf
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter with redirect, stall, and a small LIFO of interrupt return
// addresses; flags user-mode fetches below USER_BASE and returns from an empty stack.
module pc_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] USER_BASE = 16'h0800,
    parameter int          DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    pc_unit_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [15:0]   pc_q, pc_d;
    logic          valid_q, valid_d;
    logic          bad_pop_q, bad_pop_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          push, pop, bad_pop, full, rti_taken;
    logic [15:0]   top;
    logic          unused_mode_lsb;

    assign unused_mode_lsb = bus.Mode[0];

    always_comb begin
        rti_taken = bus.rti & ~bus.J & ~bus.IFID_Stall;
        full      = (cnt_q == CW'(DEPTH));
        push      = bus.J & bus.Store_Current;
        pop       = rti_taken & (cnt_q != '0);
        bad_pop   = rti_taken & (cnt_q == '0);
    end

    always_comb begin
        pc_d      = pc_q + 16'd1;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q | (push & full);
        valid_d   = ~bad_pop;
        bad_pop_d = bad_pop;
        if (bus.J) begin
            pc_d = bus.J_R;
        end else if (bus.IFID_Stall || bad_pop) begin
            pc_d = pc_q;
        end else if (pop) begin
            pc_d = top;
        end
        if (push && !full) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            bad_pop_q <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            bad_pop_q <= bad_pop_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
        end
    end

    // Entry 0 is the top of stack; a push shifts everything down, so a full push
    // drops the oldest entry off the bottom. Contents need no reset: count gates them.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stk
            logic [15:0] entry_q;
            logic [15:0] above, below;
            if (gi == 0) begin : g_first
                assign above = pc_q;
            end else begin : g_mid
                assign above = g_stk[gi-1].entry_q;
            end
            if (gi == DEPTH - 1) begin : g_last
                assign below = entry_q;
            end else begin : g_inner
                assign below = g_stk[gi+1].entry_q;
            end
            always_ff @(posedge clk) begin
                if (push) begin
                    entry_q <= above;
                end else if (pop) begin
                    entry_q <= below;
                end
            end
        end
    endgenerate

    assign top              = g_stk[0].entry_q;
    assign bus.PC           = pc_q;
    assign bus.PC_valid     = valid_q;
    assign bus.rstack_empty = (cnt_q == '0);
    assign bus.rstack_ovf   = ovf_q;
    assign bus.Illegal_PC   = (~bus.Mode[1] & (pc_q < USER_BASE) & valid_q) | bad_pop_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: queue-based reference model compared every cycle,
// plus literal expectations at the scenario checkpoints.
module tb_pc_unit;
    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] USER_BASE = 16'h0800;
    localparam int          DEPTH     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_unit_if bus();

    pc_unit #(.RESET_PC(RESET_PC), .USER_BASE(USER_BASE), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: architectural PC plus a queue (front = most recent save).
    logic [15:0] m_pc    = RESET_PC;
    logic        m_valid = 1'b0;
    logic        m_bad   = 1'b0;
    logic        m_ovf   = 1'b0;
    logic [15:0] m_stk[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc    = RESET_PC;
            m_valid = 1'b0;
            m_bad   = 1'b0;
            m_ovf   = 1'b0;
            m_stk.delete();
        end else begin
            logic bad;
            bad = 1'b0;
            if (bus.J) begin
                if (bus.Store_Current) begin
                    if (m_stk.size() == DEPTH) begin
                        void'(m_stk.pop_back());
                        m_ovf = 1'b1;
                    end
                    m_stk.push_front(m_pc);
                end
                m_pc = bus.J_R;
            end else if (bus.IFID_Stall) begin
                m_pc = m_pc;
            end else if (bus.rti) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_front();
                else bad = 1'b1;
            end else begin
                m_pc = m_pc + 16'd1;
            end
            m_bad   = bad;
            m_valid = !bad;
        end
    end

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        logic exp_ill;
        exp_ill = (!bus.Mode[1] && (m_pc < USER_BASE) && m_valid) || m_bad;
        cmp("model_PC",       bus.PC,                  m_pc);
        cmp("model_PC_valid", {15'd0, bus.PC_valid},   {15'd0, m_valid});
        cmp("model_Illegal",  {15'd0, bus.Illegal_PC}, {15'd0, exp_ill});
        cmp("model_empty",    {15'd0, bus.rstack_empty}, {15'd0, (m_stk.size() == 0)});
        cmp("model_ovf",      {15'd0, bus.rstack_ovf}, {15'd0, m_ovf});
    end

    // Applies one set of requests for exactly one rising edge; returns at edge+1.
    task automatic step(input logic j, input logic [15:0] jr, input logic sc,
                        input logic st, input logic rt);
        bus.J = j; bus.J_R = jr; bus.Store_Current = sc; bus.IFID_Stall = st; bus.rti = rt;
        @(posedge clk);
        #1;
        $display("step j=%0b jr=%h sc=%0b st=%0b rti=%0b mode=%b -> PC=%h valid=%0b ill=%0b empty=%0b ovf=%0b",
                 j, jr, sc, st, rt, bus.Mode, bus.PC, bus.PC_valid, bus.Illegal_PC,
                 bus.rstack_empty, bus.rstack_ovf);
    endtask

    task automatic idle();
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.J = 1'b0; bus.J_R = 16'h0000; bus.Store_Current = 1'b0;
        bus.IFID_Stall = 1'b0; bus.rti = 1'b0; bus.Mode = 2'b11;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_PC",    bus.PC, RESET_PC);
        cmp("rst_valid", {15'd0, bus.PC_valid}, 16'd0);
        cmp("rst_empty", {15'd0, bus.rstack_empty}, 16'd1);
        cmp("rst_ovf",   {15'd0, bus.rstack_ovf}, 16'd0);
        rst = 1'b1;

        // Free-running increment from reset
        idle(); cmp("inc1_PC", bus.PC, 16'h0001); cmp("inc1_valid", {15'd0, bus.PC_valid}, 16'd1);
        idle(); cmp("inc2_PC", bus.PC, 16'h0002);
        idle(); cmp("inc3_PC", bus.PC, 16'h0003); cmp("inc3_ill", {15'd0, bus.Illegal_PC}, 16'd0);

        // Interrupt entry and return
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0); cmp("jmp_PC", bus.PC, 16'h1234);
        cmp("jmp_nopush", {15'd0, bus.rstack_empty}, 16'd1);
        step(1'b1, 16'h0030, 1'b1, 1'b0, 1'b0); cmp("int_PC", bus.PC, 16'h0030);
        cmp("int_cnt1", {15'd0, bus.rstack_empty}, 16'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cmp("rti_PC", bus.PC, 16'h1234);
        cmp("rti_empty", {15'd0, bus.rstack_empty}, 16'd1);

        // Five nested entries into a four-deep stack
        step(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h2000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h3000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h4000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h5000, 1'b1, 1'b0, 1'b0);
        cmp("nest4_ovf", {15'd0, bus.rstack_ovf}, 16'd0);
        step(1'b1, 16'h6000, 1'b1, 1'b0, 1'b0);
        cmp("nest5_ovf", {15'd0, bus.rstack_ovf}, 16'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cmp("pop_E", bus.PC, 16'h5000);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cmp("pop_D", bus.PC, 16'h4000);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cmp("pop_C", bus.PC, 16'h3000);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cmp("pop_B", bus.PC, 16'h2000);
        cmp("pop_B_empty", {15'd0, bus.rstack_empty}, 16'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cmp("bad_rti_PC", bus.PC, 16'h2000);
        cmp("bad_rti_valid", {15'd0, bus.PC_valid}, 16'd0);
        cmp("bad_rti_ill",   {15'd0, bus.Illegal_PC}, 16'd1);
        idle(); cmp("after_bad_PC", bus.PC, 16'h2001);
        cmp("after_bad_ill", {15'd0, bus.Illegal_PC}, 16'd0);
        cmp("ovf_sticky",    {15'd0, bus.rstack_ovf}, 16'd1);

        // Priority: J beats stall and rti; stall holds; stalled rti is ignored
        step(1'b1, 16'h0100, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h0500, 1'b0, 1'b1, 1'b1); cmp("prio_PC", bus.PC, 16'h0500);
        cmp("prio_cnt", {15'd0, bus.rstack_empty}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0); cmp("stall_PC", bus.PC, 16'h0500);
        end
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1); cmp("stall_rti_PC", bus.PC, 16'h0500);
        cmp("stall_rti_cnt", {15'd0, bus.rstack_empty}, 16'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cmp("late_rti_PC", bus.PC, 16'h2001);

        // User-mode boundary and wrap
        bus.Mode = 2'b00;
        step(1'b1, 16'h0200, 1'b0, 1'b0, 1'b0); cmp("user_low_ill", {15'd0, bus.Illegal_PC}, 16'd1);
        step(1'b1, 16'h0800, 1'b0, 1'b0, 1'b0); cmp("user_base_ill", {15'd0, bus.Illegal_PC}, 16'd0);
        step(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0); cmp("user_top_ill", {15'd0, bus.Illegal_PC}, 16'd0);
        idle(); cmp("wrap_PC", bus.PC, 16'h0000); cmp("wrap_ill", {15'd0, bus.Illegal_PC}, 16'd1);
        bus.Mode = 2'b11;
        #1 cmp("admin_ill", {15'd0, bus.Illegal_PC}, 16'd0);

        // Asynchronous reset between edges with two saved entries
        step(1'b1, 16'h0a00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h0b00, 1'b1, 1'b0, 1'b0);
        idle();
        #2 rst = 1'b0;
        #1;
        cmp("arst_PC",    bus.PC, RESET_PC);
        cmp("arst_valid", {15'd0, bus.PC_valid}, 16'd0);
        cmp("arst_empty", {15'd0, bus.rstack_empty}, 16'd1);
        cmp("arst_ovf",   {15'd0, bus.rstack_ovf}, 16'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(); cmp("rel_PC", bus.PC, 16'h0001);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cmp("rel_rti_PC", bus.PC, 16'h0001);
        cmp("rel_rti_ill", {15'd0, bus.Illegal_PC}, 16'd1);
        idle();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
